// File: rtl/seq_rec_trig_arb.sv
// Round-robin trigger arbiter that grants one requester at a time access to a
// shared sequence recorder, then holds off for a programmable gap.
module seq_rec_trig_arb #(
  parameter int N_REQ    = 4,
  parameter int CNT_BITS = 16
) (
  input  logic                BUS_CLK,
  input  logic                BUS_RST,
  input  logic                ENABLE,
  input  logic                ABORT,
  input  logic [N_REQ-1:0]    REQ,
  input  logic [CNT_BITS-1:0] CAPTURE_LEN,
  input  logic [CNT_BITS-1:0] HOLDOFF,
  output logic [N_REQ-1:0]    GNT,
  output logic                SEQ_EXT_START,
  output logic [N_REQ-1:0]    DONE,
  output logic                BUSY,
  output logic [CNT_BITS-1:0] CAP_COUNT
);

  localparam int PTR_BITS = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE_HOT_LSB = N_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_CAPTURE,
    S_HOLDOFF
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_BITS-1:0]   ptr_q, ptr_d;
  logic [PTR_BITS-1:0]   win_q, win_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic                  start_q, start_d;
  logic [N_REQ-1:0]      done_q, done_d;
  logic                  busy_q, busy_d;
  logic [CNT_BITS-1:0]   cap_count_q, cap_count_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [CNT_BITS-1:0]   hold_q, hold_d;

  logic                  found;
  logic [PTR_BITS-1:0]   win_idx;
  logic [PTR_BITS-1:0]   ptr_next;
  int                    idx;
  int                    nxt;

  // Search upward from the pointer, wrapping at N_REQ, for the first request.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!found && REQ[PTR_BITS'(idx)]) begin
        found   = 1'b1;
        win_idx = PTR_BITS'(idx);
      end
    end
  end

  always_comb begin
    nxt = int'(win_idx) + 1;
    if (nxt >= N_REQ) begin
      nxt = 0;
    end
    ptr_next = PTR_BITS'(nxt);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    gnt_d       = gnt_q;
    start_d     = 1'b0;
    done_d      = '0;
    cap_count_d = cap_count_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;

    case (state_q)
      // The completion cycle is never a grant cycle, so back-to-back captures
      // are always separated by at least one quiet cycle even with no hold-off.
      S_IDLE: begin
        if (ENABLE && found && (done_q == '0)) begin
          state_d = S_START;
          win_d   = win_idx;
          gnt_d   = ONE_HOT_LSB << win_idx;
          start_d = 1'b1;
          ptr_d   = ptr_next;
        end
      end

      S_START: begin
        if (ABORT) begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end else begin
          state_d = S_CAPTURE;
          cnt_d   = (CAPTURE_LEN == '0) ? '0 : CAPTURE_LEN - CNT_BITS'(1);
          hold_d  = HOLDOFF;
        end
      end

      S_CAPTURE: begin
        if (ABORT) begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end else if (cnt_q == '0) begin
          gnt_d       = '0;
          done_d      = ONE_HOT_LSB << win_q;
          cap_count_d = cap_count_q + CNT_BITS'(1);
          if (hold_q == '0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLDOFF;
            cnt_d   = hold_q - CNT_BITS'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end

      S_HOLDOFF: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      gnt_q       <= '0;
      start_q     <= 1'b0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      cap_count_q <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      start_q     <= start_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cap_count_q <= cap_count_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
    end
  end

  assign GNT           = gnt_q;
  assign SEQ_EXT_START = start_q;
  assign DONE          = done_q;
  assign BUSY          = busy_q;
  assign CAP_COUNT     = cap_count_q;

endmodule

// File: tb/tb_seq_rec_trig_arb.sv
// Scoreboard bench for seq_rec_trig_arb: stimulus queues expected grants and
// completions, a negedge monitor pops and compares them as the DUT emits them.
module tb_seq_rec_trig_arb;

  localparam int N_REQ    = 4;
  // Narrow counters keep the capture-count wrap reachable in a short run.
  localparam int CNT_BITS = 8;

  logic                BUS_CLK = 1'b0;
  logic                BUS_RST;
  logic                ENABLE;
  logic                ABORT;
  logic [N_REQ-1:0]    REQ;
  logic [CNT_BITS-1:0] CAPTURE_LEN;
  logic [CNT_BITS-1:0] HOLDOFF;
  logic [N_REQ-1:0]    GNT;
  logic                SEQ_EXT_START;
  logic [N_REQ-1:0]    DONE;
  logic                BUSY;
  logic [CNT_BITS-1:0] CAP_COUNT;

  typedef struct packed {
    logic [N_REQ-1:0]    done;
    logic [CNT_BITS-1:0] cap;
    logic [31:0]         len;
  } exp_done_t;

  logic [N_REQ-1:0] exp_gnt_q[$];
  exp_done_t        exp_done_q[$];
  int               checks = 0;
  int               errors = 0;
  int               gnt_len = 0;
  logic [N_REQ-1:0] mon_gnt;
  exp_done_t        mon_done;

  seq_rec_trig_arb #(.N_REQ(N_REQ), .CNT_BITS(CNT_BITS)) dut (
    .BUS_CLK      (BUS_CLK),
    .BUS_RST      (BUS_RST),
    .ENABLE       (ENABLE),
    .ABORT        (ABORT),
    .REQ          (REQ),
    .CAPTURE_LEN  (CAPTURE_LEN),
    .HOLDOFF      (HOLDOFF),
    .GNT          (GNT),
    .SEQ_EXT_START(SEQ_EXT_START),
    .DONE         (DONE),
    .BUSY         (BUSY),
    .CAP_COUNT    (CAP_COUNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge BUS_CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [N_REQ-1:0] req,
                               input logic [CNT_BITS-1:0] len,
                               input logic [CNT_BITS-1:0] hold);
    ENABLE      = en;
    REQ         = req;
    CAPTURE_LEN = len;
    HOLDOFF     = hold;
  endtask

  task automatic expectCapture(input logic [N_REQ-1:0] gnt, input logic [CNT_BITS-1:0] cap,
                               input int len, input bit completes);
    exp_done_t d;
    exp_gnt_q.push_back(gnt);
    if (completes) begin
      d.done = gnt;
      d.cap  = cap;
      d.len  = 32'(len);
      exp_done_q.push_back(d);
    end
  endtask

  task automatic waitStarts(input int n, input int budget);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < budget) begin
      tick(1);
      cyc++;
      if (SEQ_EXT_START) seen++;
    end
    checkOutput("start_count", 32'(seen), 32'(n));
  endtask

  task automatic waitIdle(input int budget);
    int cyc = 0;
    while ((BUSY || (|DONE)) && cyc < budget) begin
      tick(1);
      cyc++;
    end
    checkOutput("idle_timeout", 32'(BUSY || (|DONE)), 32'd0);
  endtask

  task automatic pulseReset();
    BUS_RST = 1'b1;
    tick(2);
    BUS_RST = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a start or completion appears.
  always @(negedge BUS_CLK) begin
    if (BUS_RST) begin
      gnt_len = 0;
    end else begin
      checkOutput("gnt_onehot0", 32'($onehot0(GNT)), 32'd1);
      checkOutput("done_onehot0", 32'($onehot0(DONE)), 32'd1);
      checkOutput("gnt_done_excl", 32'((|GNT) && (|DONE)), 32'd0);
      if (SEQ_EXT_START) begin
        if (exp_gnt_q.size() == 0) begin
          checkOutput("unexpected_start", 32'(GNT), 32'd0);
        end else begin
          mon_gnt = exp_gnt_q.pop_front();
          checkOutput("start_gnt", 32'(GNT), 32'(mon_gnt));
        end
        gnt_len = 0;
      end
      if (|GNT) gnt_len++;
      if (|DONE) begin
        if (exp_done_q.size() == 0) begin
          checkOutput("unexpected_done", 32'(DONE), 32'd0);
        end else begin
          mon_done = exp_done_q.pop_front();
          checkOutput("done_vec", 32'(DONE), 32'(mon_done.done));
          checkOutput("done_cap_count", 32'(CAP_COUNT), 32'(mon_done.cap));
          checkOutput("gnt_high_cycles", 32'(gnt_len), mon_done.len);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    BUS_RST = 1'b1;
    ABORT   = 1'b0;
    applyStimulus(1'b0, '0, '0, '0);
    tick(2);
    checkOutput("rst_gnt", 32'(GNT), 32'd0);
    checkOutput("rst_start", 32'(SEQ_EXT_START), 32'd0);
    checkOutput("rst_done", 32'(DONE), 32'd0);
    checkOutput("rst_busy", 32'(BUSY), 32'd0);
    checkOutput("rst_cap", 32'(CAP_COUNT), 32'd0);
    BUS_RST = 1'b0;
    tick(1);

    $display("[TB] single request, len 5, holdoff 3");
    applyStimulus(1'b1, 4'b0001, 8'd5, 8'd3);
    expectCapture(4'b0001, 8'd1, 6, 1'b1);
    tick(1);
    checkOutput("single_start", 32'(SEQ_EXT_START), 32'd1);
    checkOutput("single_busy", 32'(BUSY), 32'd1);
    REQ = '0;
    tick(6);
    checkOutput("single_done", 32'(DONE), 32'b0001);
    checkOutput("single_gnt_clear", 32'(GNT), 32'd0);
    tick(2);
    checkOutput("holdoff_busy", 32'(BUSY), 32'd1);
    tick(1);
    checkOutput("holdoff_end", 32'(BUSY), 32'd0);
    checkOutput("single_cap", 32'(CAP_COUNT), 32'd1);

    $display("[TB] fairness, all requesting");
    pulseReset();
    checkOutput("fair_cap_reset", 32'(CAP_COUNT), 32'd0);
    applyStimulus(1'b1, 4'b1111, 8'd2, 8'd0);
    for (int i = 0; i < 5; i++) begin
      expectCapture(4'(1 << (i % 4)), 8'(i + 1), 3, 1'b1);
    end
    waitStarts(5, 100);
    REQ = '0;
    waitIdle(50);
    checkOutput("fair_cap", 32'(CAP_COUNT), 32'd5);

    $display("[TB] zero length and zero holdoff");
    applyStimulus(1'b1, 4'b0001, 8'd0, 8'd0);
    expectCapture(4'b0001, 8'd6, 2, 1'b1);
    expectCapture(4'b0001, 8'd7, 2, 1'b1);
    tick(1);
    checkOutput("zl_start", 32'(SEQ_EXT_START), 32'd1);
    tick(2);
    checkOutput("zl_done", 32'(DONE), 32'b0001);
    checkOutput("zl_busy", 32'(BUSY), 32'd0);
    tick(1);
    checkOutput("zl_gap", 32'(SEQ_EXT_START), 32'd0);
    tick(1);
    checkOutput("zl_restart", 32'(SEQ_EXT_START), 32'd1);
    REQ = '0;
    waitIdle(20);
    checkOutput("zl_cap", 32'(CAP_COUNT), 32'd7);

    $display("[TB] abort during capture");
    applyStimulus(1'b1, 4'b0100, 8'd10, 8'd0);
    expectCapture(4'b0100, 8'd0, 0, 1'b0);
    tick(1);
    checkOutput("abort_gnt", 32'(GNT), 32'b0100);
    tick(4);
    ABORT = 1'b1;
    REQ   = '0;
    tick(1);
    ABORT = 1'b0;
    checkOutput("abort_gnt_clear", 32'(GNT), 32'd0);
    checkOutput("abort_busy", 32'(BUSY), 32'd0);
    checkOutput("abort_no_done", 32'(DONE), 32'd0);
    checkOutput("abort_cap", 32'(CAP_COUNT), 32'd7);
    applyStimulus(1'b1, 4'b1111, 8'd1, 8'd0);
    expectCapture(4'b1000, 8'd8, 2, 1'b1);
    tick(1);
    checkOutput("post_abort_gnt", 32'(GNT), 32'b1000);
    REQ = '0;
    waitIdle(20);
    checkOutput("post_abort_cap", 32'(CAP_COUNT), 32'd8);

    $display("[TB] enable gating");
    applyStimulus(1'b0, 4'b0010, 8'd3, 8'd2);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput("disabled_busy", 32'(BUSY), 32'd0);
    end
    ENABLE = 1'b1;
    expectCapture(4'b0010, 8'd9, 4, 1'b1);
    tick(2);
    ENABLE = 1'b0;
    REQ    = '0;
    waitIdle(30);
    checkOutput("enable_drop_cap", 32'(CAP_COUNT), 32'd9);

    $display("[TB] reset mid-capture");
    applyStimulus(1'b1, 4'b0100, 8'd10, 8'd0);
    expectCapture(4'b0100, 8'd0, 0, 1'b0);
    tick(1);
    checkOutput("rstmid_start", 32'(SEQ_EXT_START), 32'd1);
    tick(2);
    BUS_RST = 1'b1;
    #1;
    checkOutput("rstmid_gnt", 32'(GNT), 32'd0);
    checkOutput("rstmid_start_clr", 32'(SEQ_EXT_START), 32'd0);
    checkOutput("rstmid_done", 32'(DONE), 32'd0);
    checkOutput("rstmid_busy", 32'(BUSY), 32'd0);
    checkOutput("rstmid_cap", 32'(CAP_COUNT), 32'd0);
    tick(1);
    BUS_RST = 1'b0;
    applyStimulus(1'b1, 4'b1111, 8'd1, 8'd0);
    expectCapture(4'b0001, 8'd1, 2, 1'b1);
    tick(1);
    checkOutput("rstmid_first_gnt", 32'(GNT), 32'b0001);
    REQ = '0;
    waitIdle(20);

    $display("[TB] capture count wrap");
    pulseReset();
    applyStimulus(1'b1, 4'b0001, 8'd0, 8'd0);
    for (int i = 1; i <= 255; i++) begin
      expectCapture(4'b0001, 8'(i), 2, 1'b1);
    end
    waitStarts(255, 2000);
    REQ = '0;
    waitIdle(20);
    checkOutput("wrap_max", 32'(CAP_COUNT), 32'hFF);
    applyStimulus(1'b1, 4'b0001, 8'd0, 8'd0);
    expectCapture(4'b0001, 8'h00, 2, 1'b1);
    tick(1);
    checkOutput("wrap_start", 32'(SEQ_EXT_START), 32'd1);
    REQ = '0;
    waitIdle(20);
    checkOutput("wrap_zero", 32'(CAP_COUNT), 32'd0);

    tick(2);
    checkOutput("gnt_queue_drained", 32'(exp_gnt_q.size()), 32'd0);
    checkOutput("done_queue_drained", 32'(exp_done_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
